// File: rtl/gamma_cycle_ctrl.sv
// Gamma-cycle sequencer for race-logic primitives: set pulse, temporal encoding of
// operands as rising edges, and timestamping of the first result assertion.
module gamma_cycle_ctrl #(
    parameter int unsigned GAMMA_CYCLE_WIDTH = 16,
    parameter int unsigned PULSE_WIDTH       = 8,
    parameter int unsigned N_INPUTS          = 2,
    parameter int unsigned RES_ACTIVE_LOW    = 0,
    parameter int unsigned VAL_W             = $clog2(GAMMA_CYCLE_WIDTH) + 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N_INPUTS*VAL_W-1:0] in_val,
    output logic                      set_o,
    output logic [N_INPUTS-1:0]       edge_o,
    input  logic                      res_i,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [VAL_W-1:0]          out_time,
    output logic                      busy
);

    localparam int unsigned MAX_PG = (PULSE_WIDTH > GAMMA_CYCLE_WIDTH) ? PULSE_WIDTH
                                                                        : GAMMA_CYCLE_WIDTH;
    localparam int unsigned CW_MIN = $clog2(MAX_PG) + 1;
    // Counter is at least operand-wide so lane comparisons need no truncation.
    localparam int unsigned CNT_W  = (CW_MIN > VAL_W) ? CW_MIN : VAL_W;

    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_WIDTH - 1);
    localparam logic [CNT_W-1:0] GAMMA_LAST = CNT_W'(GAMMA_CYCLE_WIDTH - 1);
    localparam logic [VAL_W-1:0] NO_HIT     = VAL_W'(GAMMA_CYCLE_WIDTH);

    typedef enum logic [1:0] {StIdle, StSet, StRun, StDone} state_e;

    state_e                      state_q;
    logic [CNT_W-1:0]            cnt_q;
    logic [CNT_W-1:0]            cnt_inc;
    logic                        hit_q;
    logic [N_INPUTS*VAL_W-1:0]   op_q;
    logic [N_INPUTS-1:0]         edge_first;
    logic [N_INPUTS-1:0]         edge_next;
    logic                        res_norm;

    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign res_norm = (RES_ACTIVE_LOW != 0) ? ~res_i : res_i;
    assign in_ready = (state_q == StIdle);
    assign busy     = (state_q != StIdle);

    // Lane levels for the upcoming RUN cycle, so edge_o is driven straight from flops.
    always_comb begin
        edge_first = '0;
        edge_next  = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            edge_first[i] = (op_q[i*VAL_W +: VAL_W] == '0);
            edge_next[i]  = (cnt_inc >= CNT_W'(op_q[i*VAL_W +: VAL_W]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            hit_q     <= 1'b0;
            op_q      <= '0;
            set_o     <= 1'b0;
            edge_o    <= '0;
            out_valid <= 1'b0;
            out_time  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        op_q    <= in_val;
                        hit_q   <= 1'b0;
                        cnt_q   <= '0;
                        set_o   <= 1'b1;
                        state_q <= StSet;
                    end
                end
                StSet: begin
                    if (cnt_q == PULSE_LAST) begin
                        cnt_q   <= '0;
                        set_o   <= 1'b0;
                        edge_o  <= edge_first;
                        state_q <= StRun;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                StRun: begin
                    if (res_norm && !hit_q) begin
                        hit_q    <= 1'b1;
                        out_time <= VAL_W'(cnt_q);
                    end
                    if (cnt_q == GAMMA_LAST) begin
                        edge_o    <= '0;
                        out_valid <= 1'b1;
                        state_q   <= StDone;
                        if (!hit_q && !res_norm) begin
                            out_time <= NO_HIT;
                        end
                    end else begin
                        cnt_q  <= cnt_inc;
                        edge_o <= edge_next;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_gamma_cycle_ctrl.sv
// Bench for gamma_cycle_ctrl: cycle-level reference model plus a scoreboard of
// expected first-hit times, with hand-written backpressure, abort and active-low runs.
module tb_gamma_cycle_ctrl;

    localparam int G = 16;
    localparam int P = 8;
    localparam int N = 2;
    localparam int W = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         in_valid, in_ready, set_o, res_i, out_valid, out_ready, busy;
    logic [N*W-1:0] in_val;
    logic [N-1:0] edge_o;
    logic [W-1:0] out_time;

    logic         b_in_valid, b_in_ready, b_set_o, b_res, b_out_valid, b_out_ready, b_busy;
    logic [W-1:0] b_in_val;
    logic [0:0]   b_edge_o;
    logic [W-1:0] b_out_time;

    gamma_cycle_ctrl #(
        .GAMMA_CYCLE_WIDTH(G), .PULSE_WIDTH(P), .N_INPUTS(N), .RES_ACTIVE_LOW(0), .VAL_W(W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_val(in_val),
        .set_o(set_o), .edge_o(edge_o), .res_i(res_i), .out_valid(out_valid),
        .out_ready(out_ready), .out_time(out_time), .busy(busy)
    );

    gamma_cycle_ctrl #(
        .GAMMA_CYCLE_WIDTH(G), .PULSE_WIDTH(P), .N_INPUTS(1), .RES_ACTIVE_LOW(1), .VAL_W(W)
    ) dut_low (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_val(b_in_val), .set_o(b_set_o), .edge_o(b_edge_o), .res_i(b_res),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_time(b_out_time), .busy(b_busy)
    );

    int n_vec = 0;
    int n_err = 0;
    int trace_err = 0;
    int sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: s counts cycles since the accepting edge (s=0 is the first SET cycle).
    logic         active;
    int           s;
    int           mode;
    logic [W-1:0] m_op0, m_op1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
            s      <= 0;
        end else if (!active) begin
            if (in_valid) begin
                active <= 1'b1;
                s      <= 0;
                m_op0  <= in_val[W-1:0];
                m_op1  <= in_val[2*W-1:W];
            end
        end else begin
            if (s >= P + G && out_ready) active <= 1'b0;
            s <= s + 1;
        end
    end

    // Primitive stand-in: 0 = less-than (lane0 before lane1), 2 = pulses at t=3 and t=7.
    always_comb begin
        case (mode)
            0:       res_i = edge_o[0] & ~edge_o[1];
            2:       res_i = active && (s == P + 3 || s == P + 7);
            default: res_i = 1'b0;
        endcase
    end

    initial begin
        logic [N-1:0] ee;
        logic         exp_set, exp_ov;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                ee[0]   = active && s >= P && s < P + G && (s - P) >= int'(m_op0);
                ee[1]   = active && s >= P && s < P + G && (s - P) >= int'(m_op1);
                exp_set = active && s < P;
                exp_ov  = active && s >= P + G;
                if (set_o !== exp_set)     trace_err++;
                if (edge_o !== ee)         trace_err++;
                if (out_valid !== exp_ov)  trace_err++;
                if (busy !== active)       trace_err++;
                if (in_ready !== !active)  trace_err++;
                if (exp_ov && sb_q.size() > 0 && out_time !== W'(sb_q[0])) trace_err++;
                if (exp_ov && out_ready) begin
                    if (sb_q.size() == 0) check("sb_underflow", 0, 1);
                    else check("out_time", out_time, sb_q.pop_front());
                    check("cycle_trace", trace_err, 0);
                    trace_err = 0;
                end
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (!active) return;
            @(posedge clk);
            #1;
        end
        check("idle_timeout", 1, 0);
    endtask

    task automatic send(input logic [W-1:0] op0, input logic [W-1:0] op1, input int md,
                        input int exp);
        wait_idle();
        mode     = md;
        in_val   = {op1, op0};
        in_valid = 1'b1;
        sb_q.push_back(exp);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_idle();
    endtask

    typedef struct {
        logic [W-1:0] op0;
        logic [W-1:0] op1;
        int           md;
        int           exp;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{5'd4,  5'd9,  0, 4};
        vecs[1] = '{5'd16, 5'd16, 1, 16};
        vecs[2] = '{5'd5,  5'd5,  2, 3};
        vecs[3] = '{5'd0,  5'd2,  0, 0};
        vecs[4] = '{5'd15, 5'd20, 0, 15};
        vecs[5] = '{5'd0,  5'd0,  0, 16};
        vecs[6] = '{5'd31, 5'd3,  0, 16};

        in_valid = 1'b0; in_val = '0; out_ready = 1'b1; mode = 1;
        b_in_valid = 1'b0; b_in_val = 5'd3; b_out_ready = 1'b1; b_res = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_set_o", set_o, 0);
        check("rst_edge_o", edge_o, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_time", out_time, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) send(vecs[i].op0, vecs[i].op1, vecs[i].md, vecs[i].exp);

        // Backpressure: 5 DONE cycles with out_ready low while in_valid stays high.
        wait_idle();
        mode = 0; in_val = {5'd9, 5'd4}; out_ready = 1'b0; in_valid = 1'b1;
        sb_q.push_back(4);
        sb_q.push_back(4);
        repeat (P + G + 6) @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_done", in_ready, 1);
        check("busy_after_done", busy, 0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_idle();

        // Abort: reset pulsed at RUN t=6.
        mode = 0; in_val = {5'd9, 5'd4}; in_valid = 1'b1;
        sb_q.push_back(4);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (P + 6) @(posedge clk);
        #1;
        check("edge_pre_abort", edge_o, 2'b01);
        rst_n = 1'b0;
        #1;
        check("abort_set_o", set_o, 0);
        check("abort_edge_o", edge_o, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(5'd4, 5'd9, 0, 4);

        // Active-low result: low pulse during SET is ignored, low at t=0 is the hit.
        b_in_valid = 1'b1;
        @(posedge clk);
        #1 b_in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 b_res = 1'b0;
        @(posedge clk);
        #1 b_res = 1'b1;
        repeat (P - 3) @(posedge clk);
        #1 b_res = 1'b0;
        check("low_set_t0", b_set_o, 0);
        @(posedge clk);
        #1 b_res = 1'b1;
        repeat (G - 2) @(posedge clk);
        #1;
        check("low_valid_early", b_out_valid, 0);
        check("low_edge_last", b_edge_o, 1);
        @(posedge clk);
        #1;
        check("low_valid", b_out_valid, 1);
        check("low_out_time", b_out_time, 0);
        repeat (2) @(posedge clk);
        #1;
        check("low_idle", b_in_ready, 1);

        check("sb_empty", sb_q.size(), 0);
        check("idle_trace", trace_err, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
